// File: rtl/dcache_axi_bridge_pkg.sv
// Shared types and AXI3 constants for the data-cache to AXI bridge.
// Holds the FSM state encoding and the fixed burst/len/size field values.
package dcache_axi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_A    = 3'd1,
    RD_D    = 3'd2,
    WR_AW   = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_SIZE_BYTE  = 2'd0;
  localparam logic [1:0] AXI_SIZE_HALF  = 2'd1;
  localparam logic [1:0] AXI_SIZE_WORD  = 2'd2;
  // SLVERR and DECERR both set bit 1 of RRESP/BRESP
  localparam int         AXI_RESP_ERR_BIT = 1;

endpackage

// File: rtl/dcache_axi_bridge_if.sv
// AXI3 master-port bundle between the bridge and the memory system.
// Handshake rule on every channel: a beat transfers on a rising clk edge where valid and ready are both 1;
//   valid, once raised, stays high with its payload stable until that edge.
interface dcache_axi_bridge_if #(
  parameter int A_WIDTH  = 32,
  parameter int ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] arid;
  logic [A_WIDTH-1:0]  araddr;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;

  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [ID_WIDTH-1:0] awid;
  logic [A_WIDTH-1:0]  awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [1:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;

  logic [ID_WIDTH-1:0] wid;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/dcache_axi_bridge.sv
// Turns the data cache's single-word request port into single-beat AXI3 reads and writes,
// one transaction at a time, reporting completion as a one-cycle s_ready pulse.
module dcache_axi_bridge
  import dcache_axi_bridge_pkg::*;
#(
  parameter int A_WIDTH  = 32,
  parameter int ID_WIDTH = 4,
  parameter int RD_ID    = 0,
  parameter int WR_ID    = 1
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] s_a,
  input  logic [31:0]        s_din,
  output logic [31:0]        s_dout,
  input  logic               s_strobe,
  input  logic [3:0]         s_wen,
  input  logic [1:0]         s_size,
  input  logic               s_rw,
  output logic               s_ready,
  output logic               bus_err,
  output state_t             state_dbg,
  dcache_axi_bridge_if.master axi
);

  state_t             state, state_n;
  logic [A_WIDTH-1:0] addr_q;
  logic [31:0]        data_q;
  logic [3:0]         wen_q;
  logic [1:0]         size_q;
  logic               aw_done, w_done;
  logic               err_q;
  logic               aw_fire, w_fire;

  // IDs, rlast and the low response bit carry no information for a lone single-beat transfer
  logic unused_inputs;
  assign unused_inputs = ^{axi.rid, axi.rlast, axi.bid,
                           axi.rresp[0], axi.bresp[0]};

  assign aw_fire = axi.awvalid && axi.awready;
  assign w_fire  = axi.wvalid && axi.wready;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wen_q   <= '0;
      size_q  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err_q   <= 1'b0;
      s_dout  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && s_strobe) begin
        addr_q  <= s_a;
        data_q  <= s_din;
        wen_q   <= s_wen;
        size_q  <= s_size;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        err_q   <= 1'b0;
      end
      if (state == WR_AW) begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end
      if (state == RD_D && axi.rvalid) begin
        s_dout <= axi.rdata;
        err_q  <= axi.rresp[AXI_RESP_ERR_BIT];
      end
      if (state == WR_RESP && axi.bvalid) err_q <= axi.bresp[AXI_RESP_ERR_BIT];
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (s_strobe) state_n = s_rw ? WR_AW : RD_A;
      RD_A:    if (axi.arready) state_n = RD_D;
      RD_D:    if (axi.rvalid) state_n = DONE;
      // AW and W complete in any order; leave once both have been taken
      WR_AW:   if ((aw_done || aw_fire) && (w_done || w_fire)) state_n = WR_RESP;
      WR_RESP: if (axi.bvalid) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Every AXI output depends only on registers, never on an AXI input
  assign axi.arvalid = (state == RD_A);
  assign axi.rready  = (state == RD_D);
  assign axi.awvalid = (state == WR_AW) && !aw_done;
  assign axi.wvalid  = (state == WR_AW) && !w_done;
  assign axi.bready  = (state == WR_RESP);
  assign s_ready     = (state == DONE);
  assign bus_err     = (state == DONE) && err_q;
  assign state_dbg   = state;

  assign axi.arid    = ID_WIDTH'(RD_ID);
  assign axi.araddr  = addr_q;
  assign axi.arlen   = AXI_LEN_SINGLE;
  assign axi.arsize  = {1'b0, size_q};
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;

  assign axi.awid    = ID_WIDTH'(WR_ID);
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = AXI_LEN_SINGLE;
  assign axi.awsize  = {1'b0, size_q};
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;

  assign axi.wid     = ID_WIDTH'(WR_ID);
  assign axi.wdata   = data_q;
  assign axi.wstrb   = wen_q;
  assign axi.wlast   = 1'b1;

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed bench for dcache_axi_bridge: an AXI slave model with programmable ready delays,
// request driver task, read-data scoreboard and handshake counters.
module tb_dcache_axi_bridge;
  import dcache_axi_bridge_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  logic [31:0] s_a, s_din, s_dout;
  logic        s_strobe, s_rw, s_ready, bus_err;
  logic [3:0]  s_wen;
  logic [1:0]  s_size;
  state_t      state_dbg;

  dcache_axi_bridge_if #(.A_WIDTH(32), .ID_WIDTH(4)) axi ();

  dcache_axi_bridge #(.A_WIDTH(32), .ID_WIDTH(4), .RD_ID(0), .WR_ID(1)) dut (
    .clk(clk), .clrn(clrn), .s_a(s_a), .s_din(s_din), .s_dout(s_dout),
    .s_strobe(s_strobe), .s_wen(s_wen), .s_size(s_size), .s_rw(s_rw),
    .s_ready(s_ready), .bus_err(bus_err), .state_dbg(state_dbg), .axi(axi)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model + monitors ----------------
  int ar_wait = 0, aw_wait = 0, w_wait = 0;
  bit b_hold = 1'b0;
  logic [31:0] rdata_cfg = '0;
  logic [1:0]  rresp_cfg = '0, bresp_cfg = '0;

  int ar_hs_n = 0, r_hs_n = 0, aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0;
  int awv_cyc = 0, wv_cyc = 0, sready_n = 0, consec_n = 0, berr_orphan = 0;
  logic [31:0] last_araddr, last_awaddr, last_wdata;
  logic [3:0]  last_arid, last_awid, last_wid, last_arlen, last_awlen, last_wstrb;
  logic [2:0]  last_arsize, last_awsize;
  logic [1:0]  last_arburst;
  logic        last_wlast;

  initial begin
    bit r_pend, b_pend, aw_got, w_got, prev_sready;
    int ar_cnt, aw_cnt, w_cnt;
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; prev_sready = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    axi.arready = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
    axi.rvalid = 1'b0; axi.bvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
    axi.rid = 4'd0; axi.rlast = 1'b1; axi.bid = 4'd1; axi.bresp = '0;
    forever begin
      @(negedge clk);
      ar_hs = axi.arvalid && axi.arready;
      r_hs  = axi.rvalid && axi.rready;
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      b_hs  = axi.bvalid && axi.bready;
      if (ar_hs) begin
        ar_hs_n++; last_araddr = axi.araddr; last_arid = axi.arid;
        last_arlen = axi.arlen; last_arsize = axi.arsize; last_arburst = axi.arburst;
      end
      if (aw_hs) begin
        aw_hs_n++; last_awaddr = axi.awaddr; last_awid = axi.awid;
        last_awlen = axi.awlen; last_awsize = axi.awsize;
      end
      if (w_hs) begin
        w_hs_n++; last_wdata = axi.wdata; last_wstrb = axi.wstrb;
        last_wid = axi.wid; last_wlast = axi.wlast;
      end
      if (r_hs) r_hs_n++;
      if (b_hs) b_hs_n++;
      if (axi.awvalid) awv_cyc++;
      if (axi.wvalid)  wv_cyc++;
      if (s_ready) sready_n++;
      if (s_ready && prev_sready) consec_n++;
      if (bus_err && !s_ready) berr_orphan++;
      prev_sready = s_ready;

      if (!clrn) begin
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
      end else begin
        if (r_hs) r_pend = 0;
        if (ar_hs) r_pend = 1;
        if (axi.arvalid && !axi.arready) ar_cnt++; else if (ar_hs) ar_cnt = 0;
        if (axi.awvalid && !axi.awready) aw_cnt++; else if (aw_hs) aw_cnt = 0;
        if (axi.wvalid && !axi.wready)   w_cnt++;  else if (w_hs)  w_cnt = 0;
        if (aw_hs) aw_got = 1;
        if (w_hs)  w_got = 1;
        if (b_hs) b_pend = 0;
        if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
      end

      @(posedge clk); #1;
      axi.arready = (ar_cnt >= ar_wait);
      axi.awready = (aw_cnt >= aw_wait);
      axi.wready  = (w_cnt >= w_wait);
      axi.rvalid  = r_pend;
      axi.rdata   = r_pend ? rdata_cfg : 32'h0;
      axi.rresp   = rresp_cfg;
      axi.bvalid  = b_pend && !b_hold;
      axi.bresp   = bresp_cfg;
    end
  end

  // ---------------- driver ----------------
  task automatic run_req(input logic rw, input logic [31:0] a, input logic [31:0] din,
                         input logic [3:0] wen, input logic [1:0] size, input bit keep,
                         output int lat, output logic err);
    bit done;
    @(posedge clk); #1;
    s_rw = rw; s_a = a; s_din = din; s_wen = wen; s_size = size; s_strobe = 1'b1;
    lat = 0; done = 0; err = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (s_ready) begin done = 1; err = bus_err; end
    end
    check("req_timeout", 64'(done), 64'd1);
    if (done && !rw && exp_q.size() > 0) check("rd_data_sb", s_dout, exp_q.pop_front());
    if (!keep) begin @(posedge clk); #1; s_strobe = 1'b0; end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int lat, lat_a, lat_b, base_aw, base_w, base_b, base_ar, base_sr, gap;
    logic err;
    bit seen;
    clrn = 1'b0; s_strobe = 1'b0; s_rw = 1'b0; s_a = '0; s_din = '0; s_wen = '0; s_size = '0;
    repeat (3) @(posedge clk);
    #1 clrn = 1'b1;
    @(negedge clk);
    check("rst_arvalid", 64'(axi.arvalid), 64'd0);
    check("rst_awvalid", 64'(axi.awvalid), 64'd0);
    check("rst_wvalid",  64'(axi.wvalid),  64'd0);
    check("rst_rready",  64'(axi.rready),  64'd0);
    check("rst_bready",  64'(axi.bready),  64'd0);
    check("rst_s_ready", 64'(s_ready),     64'd0);
    check("rst_bus_err", 64'(bus_err),     64'd0);
    check("rst_s_dout",  64'(s_dout),      64'd0);
    check("rst_state",   64'(state_dbg),   64'(IDLE));

    // 1: zero-wait word read
    rdata_cfg = 32'hDEADBEEF; rresp_cfg = 2'b00;
    exp_q.push_back(32'hDEADBEEF);
    run_req(1'b0, 32'h1FC0_0010, 32'h0, 4'h0, 2'd2, 1'b0, lat, err);
    check("t1_latency", 64'(lat), 64'd4);
    check("t1_araddr",  64'(last_araddr), 64'h1FC0_0010);
    check("t1_arsize",  64'(last_arsize), 64'd2);
    check("t1_arlen",   64'(last_arlen),  64'd0);
    check("t1_arid",    64'(last_arid),   64'd0);
    check("t1_arburst", 64'(last_arburst), 64'd1);
    check("t1_bus_err", 64'(err), 64'd0);

    // 2: byte write, AW delayed, W immediate
    aw_wait = 2; w_wait = 0;
    base_aw = awv_cyc; base_w = wv_cyc; base_b = b_hs_n; base_sr = sready_n;
    run_req(1'b1, 32'h0000_1002, 32'h00AB0000, 4'b0100, 2'd0, 1'b0, lat, err);
    check("t2_latency",   64'(lat), 64'd6);
    check("t2_awv_cyc",   64'(awv_cyc - base_aw), 64'd3);
    check("t2_wv_cyc",    64'(wv_cyc - base_w),   64'd1);
    check("t2_b_hs",      64'(b_hs_n - base_b),   64'd1);
    check("t2_sready_n",  64'(sready_n - base_sr), 64'd1);
    check("t2_awaddr",    64'(last_awaddr), 64'h0000_1002);
    check("t2_awsize",    64'(last_awsize), 64'd0);
    check("t2_awid",      64'(last_awid),   64'd1);
    check("t2_wdata",     64'(last_wdata),  64'h00AB0000);
    check("t2_wstrb",     64'(last_wstrb),  64'b0100);
    check("t2_wlast",     64'(last_wlast),  64'd1);
    check("t2_wid",       64'(last_wid),    64'd1);
    check("t2_dout_kept", 64'(s_dout),      64'hDEADBEEF);

    // 3: W before AW, then AW before W
    base_aw = aw_hs_n; base_w = w_hs_n; base_b = b_hs_n;
    aw_wait = 2; w_wait = 0;
    run_req(1'b1, 32'h0000_2000, 32'h1111_2222, 4'hF, 2'd2, 1'b0, lat_a, err);
    aw_wait = 0; w_wait = 2;
    run_req(1'b1, 32'h0000_2004, 32'h3333_4444, 4'hF, 2'd2, 1'b0, lat_b, err);
    check("t3_lat_w_first",  64'(lat_a), 64'd6);
    check("t3_lat_aw_first", 64'(lat_b), 64'd6);
    check("t3_aw_hs",        64'(aw_hs_n - base_aw), 64'd2);
    check("t3_w_hs",         64'(w_hs_n - base_w),   64'd2);
    check("t3_b_hs",         64'(b_hs_n - base_b),   64'd2);
    check("t3_wdata",        64'(last_wdata), 64'h3333_4444);
    w_wait = 0;

    // 4: read with SLVERR
    rdata_cfg = 32'h1234_5678; rresp_cfg = 2'b10;
    exp_q.push_back(32'h1234_5678);
    run_req(1'b0, 32'h0000_0040, 32'h0, 4'h0, 2'd2, 1'b0, lat, err);
    check("t4_bus_err", 64'(err), 64'd1);
    check("t4_latency", 64'(lat), 64'd4);
    rresp_cfg = 2'b00;

    // 5: back-to-back reads with s_strobe held high across completion
    rdata_cfg = 32'hCAFE_F00D;
    base_ar = ar_hs_n;
    exp_q.push_back(32'hCAFE_F00D);
    run_req(1'b0, 32'h0000_0080, 32'h0, 4'h0, 2'd1, 1'b1, lat, err);
    gap = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); gap++;
      if (axi.arvalid) seen = 1;
    end
    check("t5_gap_to_ar", 64'(gap), 64'd2);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (s_ready) seen = 1;
    end
    check("t5_second_done", 64'(seen), 64'd1);
    check("t5_dout", 64'(s_dout), 64'hCAFE_F00D);
    check("t5_ar_hs", 64'(ar_hs_n - base_ar), 64'd2);
    check("t5_arsize", 64'(last_arsize), 64'd1);
    @(posedge clk); #1 s_strobe = 1'b0;

    // 6: reset while waiting for B
    b_hold = 1'b1;
    @(posedge clk); #1;
    s_rw = 1'b1; s_a = 32'h0000_3000; s_din = 32'h5555_AAAA; s_wen = 4'hF; s_size = 2'd2;
    s_strobe = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (state_dbg == WR_RESP) seen = 1;
    end
    check("t6_reach_wr_resp", 64'(seen), 64'd1);
    @(posedge clk); #1 clrn = 1'b0; s_strobe = 1'b0;
    @(posedge clk); #1 clrn = 1'b1; b_hold = 1'b0;
    @(negedge clk);
    check("t6_state",   64'(state_dbg), 64'(IDLE));
    check("t6_valids",  64'({axi.arvalid, axi.awvalid, axi.wvalid}), 64'd0);
    check("t6_readies", 64'({axi.rready, axi.bready}), 64'd0);
    check("t6_s_ready", 64'({s_ready, bus_err}), 64'd0);
    rdata_cfg = 32'h0BAD_F00D;
    exp_q.push_back(32'h0BAD_F00D);
    run_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, 2'd2, 1'b0, lat, err);
    check("t6_fresh_latency", 64'(lat), 64'd4);
    check("t6_fresh_err", 64'(err), 64'd0);

    repeat (3) @(negedge clk);
    check("sready_consecutive", 64'(consec_n), 64'd0);
    check("bus_err_orphan", 64'(berr_orphan), 64'd0);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
